// File: rtl/instr_fetch_queue_if.sv
// Shared types and the bundled port interface for instr_fetch_queue.
// if_reason_t tags every fetched record with why its PC was chosen.
package instr_fetch_queue_pkg;
  typedef enum logic [2:0] {
    IF_PREFETCH   = 3'd0,
    IF_FENCE_I    = 3'd1,
    IF_PREDICT    = 3'd2,
    IF_MISPREDICT = 3'd3,
    IF_EMPTY      = 3'd4,
    IF_FLUSH      = 3'd5
  } if_reason_t;
endpackage

interface instr_fetch_queue_if #(
  parameter int XLEN = 64
);
  // redirect / translation context
  logic                              redir_valid_i;
  logic [XLEN-1:0]                   redir_pc_i;
  instr_fetch_queue_pkg::if_reason_t redir_reason_i;
  logic                              prv_i;
  logic                              sum_i;
  logic [XLEN-1:0]                   atp_i;
  // icache request
  logic                              req_valid_o;
  logic                              req_ready_i;
  logic [XLEN-1:0]                   req_pc_o;
  instr_fetch_queue_pkg::if_reason_t req_reason_o;
  logic                              req_prv_o;
  logic                              req_sum_o;
  logic [XLEN-1:0]                   req_atp_o;
  // icache response
  logic                              resp_valid_i;
  logic [31:0]                       resp_instr_i;
  logic                              resp_exception_i;
  // decode side
  logic                              o_valid;
  logic                              o_ready;
  logic [XLEN-1:0]                   o_pc;
  logic [31:0]                       o_instr;
  instr_fetch_queue_pkg::if_reason_t o_reason;
  logic                              o_ex_valid;

  // the fetch queue itself
  modport slave (
    input  redir_valid_i, redir_pc_i, redir_reason_i, prv_i, sum_i, atp_i,
    input  req_ready_i, resp_valid_i, resp_instr_i, resp_exception_i, o_ready,
    output req_valid_o, req_pc_o, req_reason_o, req_prv_o, req_sum_o, req_atp_o,
    output o_valid, o_pc, o_instr, o_reason, o_ex_valid
  );

  // surrounding pipeline / cache
  modport master (
    output redir_valid_i, redir_pc_i, redir_reason_i, prv_i, sum_i, atp_i,
    output req_ready_i, resp_valid_i, resp_instr_i, resp_exception_i, o_ready,
    input  req_valid_o, req_pc_o, req_reason_o, req_prv_o, req_sum_o, req_atp_o,
    input  o_valid, o_pc, o_instr, o_reason, o_ex_valid
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetcher: one outstanding icache request, DEPTH-entry response
// queue toward decode, redirect/flush with squashing of stale responses.
// Optional static branch prediction is enabled by defining the macro
// INSTR_FETCH_STATIC_BP_EN; without it fetch is strictly sequential.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);
  localparam logic [PW-1:0]   PTR_ONE   = PW'(1'b1);
  localparam logic [XLEN-1:0] STEP2     = XLEN'(3'd2);
  localparam logic [XLEN-1:0] STEP4     = XLEN'(3'd4);
  localparam logic [XLEN-1:0] ALIGN_MSK = ~(XLEN'(1'b1));

  // IDLE may issue, WAIT has a live request out, STALE has a squashed
  // request out, HALT sits on an enqueued fault until redirected.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STALE, S_HALT} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    if_reason_t      reason;
    logic            ex;
  } entry_t;

  state_t          state_q;
  logic            req_valid_q;
  logic [XLEN-1:0] req_pc_q;
  if_reason_t      req_reason_q;
  logic [XLEN-1:0] npc_q;
  if_reason_t      npc_reason_q;
  logic            pend_q;
  logic [XLEN-1:0] pend_pc_q;
  if_reason_t      pend_reason_q;
  logic            prv_q;
  logic            sum_q;
  logic [XLEN-1:0] atp_q;
  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rptr_q;
  logic [PW-1:0]   wptr_q;
  logic [CW-1:0]   cnt_q;
  logic            o_valid_q;
  entry_t          head_q;

  logic            fire_s;
  logic            enq_s;
  logic            pop_s;
  logic            issue_s;
  entry_t          new_entry_s;
  logic [PW-1:0]   rptr_n_s;
  logic [CW-1:0]   cnt_n_s;
  entry_t          head_n_s;
  logic [XLEN-1:0] seq_pc_s;
  logic [XLEN-1:0] next_pc_s;
  if_reason_t      next_reason_s;

  // Handshake qualifiers and next queue occupancy/head; a redirect masks
  // both enqueue and pop because it flushes the queue in the same edge.
  always_comb begin
    fire_s      = req_valid_q & bus.req_ready_i;
    enq_s       = (state_q == S_WAIT) & bus.resp_valid_i & ~bus.redir_valid_i;
    pop_s       = bus.o_ready & (cnt_q != '0) & ~bus.redir_valid_i;
    issue_s     = (state_q == S_IDLE) & ~req_valid_q & ~bus.redir_valid_i & (cnt_q < DEPTH_C);
    new_entry_s = '{pc: req_pc_q, instr: bus.resp_instr_i, reason: req_reason_q,
                    ex: bus.resp_exception_i};
    rptr_n_s    = pop_s ? (rptr_q + PTR_ONE) : rptr_q;
    cnt_n_s     = cnt_q + CW'(enq_s) - CW'(pop_s);
    if (enq_s && (wptr_q == rptr_n_s)) begin
      head_n_s = new_entry_s;
    end else begin
      head_n_s = mem_q[rptr_n_s];
    end
    if (bus.resp_instr_i[1:0] == 2'b11) begin
      seq_pc_s = req_pc_q + STEP4;
    end else begin
      seq_pc_s = req_pc_q + STEP2;
    end
  end

`ifdef INSTR_FETCH_STATIC_BP_EN
  logic            bp_taken_s;
  logic [XLEN-1:0] bp_imm_s;

  // Static prediction: jumps taken, conditional branches taken when backward.
  always_comb begin
    bp_taken_s = 1'b0;
    bp_imm_s   = '0;
    if (bus.resp_instr_i[1:0] == 2'b11) begin
      case (bus.resp_instr_i[6:0])
        7'b1101111: begin
          bp_taken_s = 1'b1;
          bp_imm_s   = {{(XLEN-21){bus.resp_instr_i[31]}}, bus.resp_instr_i[31],
                        bus.resp_instr_i[19:12], bus.resp_instr_i[20],
                        bus.resp_instr_i[30:21], 1'b0};
        end
        7'b1100011: begin
          bp_taken_s = bus.resp_instr_i[31];
          bp_imm_s   = {{(XLEN-13){bus.resp_instr_i[31]}}, bus.resp_instr_i[31],
                        bus.resp_instr_i[7], bus.resp_instr_i[30:25],
                        bus.resp_instr_i[11:8], 1'b0};
        end
        default: begin
          bp_taken_s = 1'b0;
          bp_imm_s   = '0;
        end
      endcase
    end else if (bus.resp_instr_i[1:0] == 2'b01) begin
      case (bus.resp_instr_i[15:13])
        3'b101: begin
          bp_taken_s = 1'b1;
          bp_imm_s   = {{(XLEN-12){bus.resp_instr_i[12]}}, bus.resp_instr_i[12],
                        bus.resp_instr_i[8], bus.resp_instr_i[10:9], bus.resp_instr_i[6],
                        bus.resp_instr_i[7], bus.resp_instr_i[2], bus.resp_instr_i[11],
                        bus.resp_instr_i[5:3], 1'b0};
        end
        3'b110, 3'b111: begin
          bp_taken_s = bus.resp_instr_i[12];
          bp_imm_s   = {{(XLEN-9){bus.resp_instr_i[12]}}, bus.resp_instr_i[12],
                        bus.resp_instr_i[6:5], bus.resp_instr_i[2],
                        bus.resp_instr_i[11:10], bus.resp_instr_i[4:3], 1'b0};
        end
        default: begin
          bp_taken_s = 1'b0;
          bp_imm_s   = '0;
        end
      endcase
    end else begin
      bp_taken_s = 1'b0;
      bp_imm_s   = '0;
    end
    if (bp_taken_s) begin
      next_pc_s     = req_pc_q + bp_imm_s;
      next_reason_s = IF_PREDICT;
    end else begin
      next_pc_s     = seq_pc_s;
      next_reason_s = IF_PREFETCH;
    end
  end
`else
  // Sequential fetch only.
  always_comb begin
    next_pc_s     = seq_pc_s;
    next_reason_s = IF_PREFETCH;
  end
`endif

  // Fetch FSM, request channel, redirect capture and output queue.
  // After rst the FSM is IDLE and ignores responses, so a reply to a request
  // issued before reset is dropped (the cache is expected to reset as well).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_valid_q   <= 1'b0;
      req_pc_q      <= '0;
      req_reason_q  <= IF_PREFETCH;
      npc_q         <= '0;
      npc_reason_q  <= IF_PREFETCH;
      pend_q        <= 1'b1;
      pend_pc_q     <= RESET_PC & ALIGN_MSK;
      pend_reason_q <= IF_FENCE_I;
      prv_q         <= 1'b0;
      sum_q         <= 1'b0;
      atp_q         <= '0;
      rptr_q        <= '0;
      wptr_q        <= '0;
      cnt_q         <= '0;
      o_valid_q     <= 1'b0;
      head_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus.redir_valid_i) begin
      // a redirect wins over any response, pop or pending request
      req_valid_q   <= 1'b0;
      pend_q        <= 1'b1;
      pend_pc_q     <= bus.redir_pc_i & ALIGN_MSK;
      pend_reason_q <= bus.redir_reason_i;
      prv_q         <= bus.prv_i;
      sum_q         <= bus.sum_i;
      atp_q         <= bus.atp_i;
      rptr_q        <= '0;
      wptr_q        <= '0;
      cnt_q         <= '0;
      o_valid_q     <= 1'b0;
      case (state_q)
        S_WAIT, S_STALE: state_q <= bus.resp_valid_i ? S_IDLE : S_STALE;
        S_IDLE:          state_q <= fire_s ? S_STALE : S_IDLE;
        S_HALT:          state_q <= S_IDLE;
        default:         state_q <= S_IDLE;
      endcase
    end else begin
      if (enq_s) begin
        mem_q[wptr_q] <= new_entry_s;
        wptr_q        <= wptr_q + PTR_ONE;
      end
      rptr_q    <= rptr_n_s;
      cnt_q     <= cnt_n_s;
      o_valid_q <= (cnt_n_s != '0);
      head_q    <= head_n_s;
      case (state_q)
        S_IDLE: begin
          if (fire_s) begin
            req_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end else if (issue_s) begin
            req_valid_q  <= 1'b1;
            req_pc_q     <= pend_q ? pend_pc_q : npc_q;
            req_reason_q <= pend_q ? pend_reason_q : npc_reason_q;
            pend_q       <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.resp_valid_i) begin
            npc_q        <= next_pc_s;
            npc_reason_q <= next_reason_s;
            state_q      <= bus.resp_exception_i ? S_HALT : S_IDLE;
          end
        end
        S_STALE: begin
          if (bus.resp_valid_i) begin
            state_q <= S_IDLE;
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_valid_o  = req_valid_q;
  assign bus.req_pc_o     = req_pc_q;
  assign bus.req_reason_o = req_reason_q;
  assign bus.req_prv_o    = prv_q;
  assign bus.req_sum_o    = sum_q;
  assign bus.req_atp_o    = atp_q;
  assign bus.o_valid      = o_valid_q;
  assign bus.o_pc         = head_q.pc;
  assign bus.o_instr      = head_q.instr;
  assign bus.o_reason     = head_q.reason;
  assign bus.o_ex_valid   = head_q.ex;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a behavioural icache and an
// expected-record scoreboard checked at every pop.
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_queue_if #(.XLEN(XLEN)) bus ();

  instr_fetch_queue #(.XLEN(XLEN), .DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    if_reason_t  reason;
    logic        ex;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] imem [logic [63:0]];
  int          resp_delay = 0;
  logic [63:0] fault_pc = 64'hFFFF_FFFF_FFFF_FFFF;
  int          fire_count = 0;
  int          cyc = 0;
  logic [63:0] pq[$];
  int          dq[$];
  logic [63:0] rpc;

  function automatic logic [31:0] mem_word(input logic [63:0] pc);
    if (imem.exists(pc)) return imem[pc];
    return {pc[24:0], 7'b0010011};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] pc, input if_reason_t r, input logic ex);
    exp_t e;
    e.pc = pc; e.instr = mem_word(pc); e.reason = r; e.ex = ex;
    sb.push_back(e);
  endtask

  task automatic pop_one(input string tag);
    exp_t e;
    bit   got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (bus.o_valid === 1'b1) got = 1'b1;
      else step();
    end
    chk({tag, "_valid"}, 64'(got), 64'd1);
    if (got) begin
      n_chk++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, "_pc"}, bus.o_pc, e.pc);
        chk({tag, "_instr"}, 64'(bus.o_instr), 64'(e.instr));
        chk({tag, "_reason"}, 64'(bus.o_reason), 64'(e.reason));
        chk({tag, "_ex"}, 64'(bus.o_ex_valid), 64'(e.ex));
      end
      bus.o_ready = 1'b1;
      step();
      bus.o_ready = 1'b0;
    end
  endtask

  task automatic wait_req(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (bus.req_valid_o === 1'b1) seen = 1'b1;
      else step();
    end
    chk({tag, "_req_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic redirect(input logic [63:0] pc, input if_reason_t r, input logic prv,
                          input logic sum, input logic [63:0] atp, input string tag);
    bus.redir_valid_i  = 1'b1;
    bus.redir_pc_i     = pc;
    bus.redir_reason_i = r;
    bus.prv_i          = prv;
    bus.sum_i          = sum;
    bus.atp_i          = atp;
    step();
    bus.redir_valid_i  = 1'b0;
    sb.delete();
    chk({tag, "_flush"}, 64'(bus.o_valid), 64'd0);
  endtask

  // Behavioural icache: in-order, resp_delay extra cycles, resets with rst.
  always begin
    @(negedge clk);
    if (!rst && bus.req_valid_o && bus.req_ready_i) begin
      pq.push_back(bus.req_pc_o);
      dq.push_back(cyc + 1 + resp_delay);
      fire_count++;
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.resp_valid_i     = 1'b0;
    bus.resp_instr_i     = 32'h0;
    bus.resp_exception_i = 1'b0;
    if (rst) begin
      pq.delete();
      dq.delete();
    end else if (dq.size() > 0 && dq[0] <= cyc) begin
      rpc = pq.pop_front();
      void'(dq.pop_front());
      bus.resp_valid_i     = 1'b1;
      bus.resp_instr_i     = mem_word(rpc);
      bus.resp_exception_i = (rpc == fault_pc);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #300000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc;
    bus.redir_valid_i  = 1'b0;
    bus.redir_pc_i     = 64'h0;
    bus.redir_reason_i = IF_PREFETCH;
    bus.prv_i          = 1'b0;
    bus.sum_i          = 1'b0;
    bus.atp_i          = 64'h0;
    bus.req_ready_i    = 1'b1;
    bus.o_ready        = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_req_valid", 64'(bus.req_valid_o), 64'd0);

    // first request right after reset, then fill the queue with decode stalled
    rst = 1'b0;
    step();
    chk("first_req_valid", 64'(bus.req_valid_o), 64'd1);
    chk("first_req_pc", bus.req_pc_o, 64'h0);
    chk("first_req_reason", 64'(bus.req_reason_o), 64'(IF_FENCE_I));
    chk("first_req_atp", bus.req_atp_o, 64'h0);
    push_exp(64'h0, IF_FENCE_I, 1'b0);
    push_exp(64'h4, IF_PREFETCH, 1'b0);
    push_exp(64'h8, IF_PREFETCH, 1'b0);
    push_exp(64'hC, IF_PREFETCH, 1'b0);
    repeat (20) step();
    chk("full_fires", 64'(fire_count), 64'd4);
    chk("full_no_req", 64'(bus.req_valid_o), 64'd0);
    resp_delay = 3;
    pop_one("stream0");
    pop_one("stream1");
    pop_one("stream2");
    pop_one("stream3");

    // redirect while a request is outstanding: its response must be dropped
    wait_req("pre_redir");
    step();
    redirect(64'h8000_0102, IF_MISPREDICT, 1'b1, 1'b1, 64'h8000_0000_0000_1234, "wait_redir");
    resp_delay = 0;
    chk("stale_no_req", 64'(bus.req_valid_o), 64'd0);
    step();
    step();
    chk("stale_hold", 64'(bus.req_valid_o), 64'd0);
    wait_req("redir");
    chk("redir_pc", bus.req_pc_o, 64'h8000_0102);
    chk("redir_reason", 64'(bus.req_reason_o), 64'(IF_MISPREDICT));
    chk("redir_prv", 64'(bus.req_prv_o), 64'd1);
    chk("redir_sum", 64'(bus.req_sum_o), 64'd1);
    chk("redir_atp", bus.req_atp_o, 64'h8000_0000_0000_1234);
    push_exp(64'h8000_0102, IF_MISPREDICT, 1'b0);
    pop_one("redir_head");

    // compressed then 32-bit instruction at 0x1002 (second redirect PC has bit0 set)
    imem[64'h1002] = 32'h0000_0001;
    redirect(64'h1002, IF_FLUSH, 1'b0, 1'b0, 64'h0, "rvc");
    push_exp(64'h1002, IF_FLUSH, 1'b0);
    push_exp(64'h1004, IF_PREFETCH, 1'b0);
    pop_one("rvc0");
    pop_one("rvc1");
    imem[64'h1002] = 32'h0000_0013;
    redirect(64'h1003, IF_FLUSH, 1'b0, 1'b0, 64'h0, "rv32");
    push_exp(64'h1002, IF_FLUSH, 1'b0);
    push_exp(64'h1006, IF_PREFETCH, 1'b0);
    pop_one("rv32_0");
    pop_one("rv32_1");

    // backward BEQ, offset -8
    imem[64'h2000] = 32'hFE00_0CE3;
    redirect(64'h2000, IF_MISPREDICT, 1'b0, 1'b0, 64'h0, "beq");
    push_exp(64'h2000, IF_MISPREDICT, 1'b0);
`ifdef INSTR_FETCH_STATIC_BP_EN
    push_exp(64'h1FF8, IF_PREDICT, 1'b0);
`else
    push_exp(64'h2004, IF_PREFETCH, 1'b0);
`endif
    pop_one("beq0");
    pop_one("beq1");

    // page fault halts fetch until the next redirect
    fault_pc = 64'h3000;
    redirect(64'h3000, IF_FLUSH, 1'b0, 1'b0, 64'h0, "fault");
    push_exp(64'h3000, IF_FLUSH, 1'b1);
    pop_one("fault_head");
    fc = fire_count;
    repeat (10) step();
    chk("halt_fires", 64'(fire_count), 64'(fc));
    chk("halt_no_req", 64'(bus.req_valid_o), 64'd0);
    fault_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    redirect(64'h4000, IF_FENCE_I, 1'b0, 1'b0, 64'h0, "resume");
    push_exp(64'h4000, IF_FENCE_I, 1'b0);
    pop_one("resume_head");

    // back-to-back redirects: the last one wins
    bus.redir_valid_i  = 1'b1;
    bus.redir_pc_i     = 64'h5000;
    bus.redir_reason_i = IF_FLUSH;
    step();
    bus.redir_pc_i     = 64'h6000;
    bus.redir_reason_i = IF_MISPREDICT;
    step();
    bus.redir_valid_i  = 1'b0;
    sb.delete();
    push_exp(64'h6000, IF_MISPREDICT, 1'b0);
    pop_one("b2b");

    // reset in mid-stream restarts at RESET_PC
    rst = 1'b1;
    step();
    step();
    sb.delete();
    chk("rst2_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst2_req_valid", 64'(bus.req_valid_o), 64'd0);
    rst = 1'b0;
    step();
    chk("rst2_req_pc", bus.req_pc_o, 64'h0);
    chk("rst2_req_reason", 64'(bus.req_reason_o), 64'(IF_FENCE_I));
    push_exp(64'h0, IF_FENCE_I, 1'b0);
    push_exp(64'h4, IF_PREFETCH, 1'b0);
    pop_one("rst2_0");
    pop_one("rst2_1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
